// File: rtl/bus_pkg.sv
// Shared definitions for the four-phase external bus: phase codes used by
// initiator and target, plus the target FSM state encoding.
package bus_pkg;

    typedef enum logic [1:0] {
        BUS_ADDR_LO = 2'b00,
        BUS_ADDR_HI = 2'b01,
        BUS_READ    = 2'b10,
        BUS_WRITE   = 2'b11
    } bus_phase_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } tgt_state_e;

endpackage

// File: rtl/bus_target_if.sv
// Four-phase external bus: initiator (master) drives req/phase/data,
// target (slave) returns ack, read data and output enable.
interface bus_target_if;

    logic       bus_handshake_req;
    logic       bus_handshake_ack;
    logic [1:0] bus_state;
    logic [7:0] bus_data_in;
    logic [7:0] bus_data_out;
    logic       bus_output_enable;

    modport master (
        output bus_handshake_req,
        output bus_state,
        output bus_data_in,
        input  bus_handshake_ack,
        input  bus_data_out,
        input  bus_output_enable
    );

    modport slave (
        input  bus_handshake_req,
        input  bus_state,
        input  bus_data_in,
        output bus_handshake_ack,
        output bus_data_out,
        output bus_output_enable
    );

endinterface

// File: rtl/bus_sync.sv
// N-flop level synchronizer with synchronous active-high reset; N must be >= 2.
module bus_sync #(
    parameter int unsigned N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [N-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[N-2:0], i_d};
        end
    end

    assign o_q = r_sync[N-1];

endmodule

// File: rtl/bus_target.sv
// Target endpoint of the four-phase bus: assembles the 16-bit address from two
// address phases and performs one local memory access per data phase.
module bus_target
    import bus_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    bus_target_if.slave  bus,
    output logic [15:0]  mem_addr,
    output logic         mem_read,
    output logic         mem_write,
    output logic [7:0]   mem_wdata,
    input  logic [7:0]   mem_rdata,
    input  logic         mem_ready,
    output logic         protocol_error
);

    logic       w_req_s;
    logic       w_accept;
    logic       w_done;
    bus_phase_e w_phase;

    tgt_state_e r_state;
    tgt_state_e w_state_nxt;

    logic [15:0] r_addr;
    logic [7:0]  r_wdata;
    logic [7:0]  r_rdata;
    logic        r_is_read;
    logic        r_lo_seen;
    logic        r_hi_seen;
    logic        r_ack;
    logic        r_oe;
    logic        r_rd;
    logic        r_wr;
    logic        r_perr;

    bus_sync #(
        .N (SYNC_STAGES)
    ) u_req_sync (
        .clk (clk),
        .rst (rst),
        .i_d (bus.bus_handshake_req),
        .o_q (w_req_s)
    );

    assign w_phase  = bus_phase_e'(bus.bus_state);
    assign w_accept = (r_state == IDLE) && w_req_s;
    // mem_ready only counts once the strobe is actually on the port.
    assign w_done   = (r_state == ACCESS) && (r_rd || r_wr) && mem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_req_s) begin
                    if (w_phase == BUS_READ || w_phase == BUS_WRITE) begin
                        w_state_nxt = ACCESS;
                    end else begin
                        w_state_nxt = ACK;
                    end
                end
            end
            ACCESS: begin
                if (w_done) begin
                    w_state_nxt = ACK;
                end
            end
            ACK: begin
                if (!w_req_s) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_is_read <= 1'b0;
            r_lo_seen <= 1'b0;
            r_hi_seen <= 1'b0;
            r_ack     <= 1'b0;
            r_oe      <= 1'b0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_perr    <= 1'b0;
        end else begin
            // ack/oe lag the state by one flop so both rise and fall together.
            r_ack  <= (r_state == ACK);
            r_oe   <= (r_state == ACK) && r_is_read;
            r_perr <= 1'b0;

            if (w_accept) begin
                unique case (w_phase)
                    BUS_ADDR_LO: begin
                        r_addr[7:0] <= bus.bus_data_in;
                        r_lo_seen   <= 1'b1;
                        r_is_read   <= 1'b0;
                    end
                    BUS_ADDR_HI: begin
                        r_addr[15:8] <= bus.bus_data_in;
                        r_hi_seen    <= 1'b1;
                        r_is_read    <= 1'b0;
                    end
                    default: begin
                        r_wdata   <= bus.bus_data_in;
                        r_is_read <= (w_phase == BUS_READ);
                        r_perr    <= !(r_lo_seen && r_hi_seen);
                    end
                endcase
            end

            if ((r_state == ACCESS) && !w_done) begin
                r_rd <= r_is_read;
                r_wr <= !r_is_read;
            end else begin
                r_rd <= 1'b0;
                r_wr <= 1'b0;
            end

            if (w_done) begin
                if (r_rd) begin
                    r_rdata <= mem_rdata;
                end
                r_lo_seen <= 1'b0;
                r_hi_seen <= 1'b0;
            end
        end
    end

    assign bus.bus_handshake_ack = r_ack;
    assign bus.bus_output_enable = r_oe;
    assign bus.bus_data_out      = r_rdata;
    assign mem_addr              = r_addr;
    assign mem_wdata             = r_wdata;
    assign mem_read              = r_rd;
    assign mem_write             = r_wr;
    assign protocol_error        = r_perr;

endmodule

// File: tb/tb_bus_target.sv
// Directed bench for bus_target: initiator tasks, a variable-latency memory
// model and per-scenario checks against hand-computed timing and data.
module tb_bus_target;
    import bus_pkg::*;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_ready = 1'b0;
    logic        protocol_error;

    int nvec = 0;
    int nerr = 0;

    // memory model / monitor state (written only by the monitor)
    int          mcnt = 0;
    int          rd_cyc = 0;
    int          wr_cyc = 0;
    int          acc_cnt = 0;
    int          perr_cnt = 0;
    int          unstable = 0;
    logic [15:0] last_addr = '0;
    logic [7:0]  last_wdata = '0;
    logic        strobe_prev = 1'b0;
    // model controls (written only by the stimulus)
    int          mem_lat = 1;
    logic        force_ready = 1'b0;

    bus_target_if bif ();

    bus_target #(
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bif.slave),
        .mem_addr       (mem_addr),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ready      (mem_ready),
        .protocol_error (protocol_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_read === 1'b1 || mem_write === 1'b1) begin
            mcnt = mcnt + 1;
            mem_ready = (mcnt >= mem_lat);
            if (mem_read === 1'b1) rd_cyc = rd_cyc + 1;
            if (mem_write === 1'b1) wr_cyc = wr_cyc + 1;
            if (!strobe_prev) begin
                acc_cnt = acc_cnt + 1;
                last_addr = mem_addr;
                last_wdata = mem_wdata;
            end else if (mem_addr !== last_addr || (mem_write && mem_wdata !== last_wdata)) begin
                unstable = unstable + 1;
            end
            strobe_prev = 1'b1;
        end else begin
            mcnt = 0;
            mem_ready = force_ready;
            strobe_prev = 1'b0;
        end
        if (protocol_error === 1'b1) perr_cnt = perr_cnt + 1;
    end

    task automatic do_phase(input logic [1:0] ph, input logic [7:0] d, input int hold,
                            output int rise_lat, output int fall_lat, output logic [7:0] rd,
                            output logic oe_rise, output bit oe_bad, output bit ack_dropped);
        rise_lat = -1;
        fall_lat = -1;
        rd = '0;
        oe_rise = 1'b0;
        oe_bad = 1'b0;
        ack_dropped = 1'b0;
        @(negedge clk);
        bif.bus_state = ph;
        bif.bus_data_in = d;
        bif.bus_handshake_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bif.bus_handshake_ack === 1'b1) begin
                rise_lat = i;
                break;
            end
            if (bif.bus_output_enable !== 1'b0) oe_bad = 1'b1;
        end
        rd = bif.bus_data_out;
        oe_rise = bif.bus_output_enable;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (bif.bus_handshake_ack !== 1'b1) ack_dropped = 1'b1;
            if (bif.bus_output_enable !== (ph == BUS_READ)) oe_bad = 1'b1;
        end
        bif.bus_handshake_req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bif.bus_handshake_ack === 1'b0) begin
                fall_lat = i;
                if (bif.bus_output_enable !== 1'b0) oe_bad = 1'b1;
                break;
            end
            if (bif.bus_output_enable !== (ph == BUS_READ)) oe_bad = 1'b1;
        end
    endtask

    task automatic test_reset();
        bif.bus_handshake_req = 1'b0;
        bif.bus_state = 2'b00;
        bif.bus_data_in = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        nvec++; if (bif.bus_handshake_ack !== 1'b0) begin nerr++; $display("FAIL reset_ack: got %b exp 0", bif.bus_handshake_ack); end
        nvec++; if (bif.bus_output_enable !== 1'b0) begin nerr++; $display("FAIL reset_oe: got %b exp 0", bif.bus_output_enable); end
        nvec++; if (bif.bus_data_out !== 8'h00) begin nerr++; $display("FAIL reset_dout: got %h exp 00", bif.bus_data_out); end
        nvec++; if ({mem_read, mem_write, protocol_error} !== 3'b000) begin nerr++; $display("FAIL reset_strobes: got %b exp 000", {mem_read, mem_write, protocol_error}); end
        nvec++; if (mem_addr !== 16'h0000) begin nerr++; $display("FAIL reset_addr: got %h exp 0000", mem_addr); end
        nvec++; if (mem_wdata !== 8'h00) begin nerr++; $display("FAIL reset_wdata: got %h exp 00", mem_wdata); end
        nvec++; if (dut.r_state !== IDLE) begin nerr++; $display("FAIL reset_state: got %0d exp %0d", dut.r_state, IDLE); end
        rst = 1'b0;
    endtask

    task automatic test_error_after_reset();
        int rl, fl, p0, r0;
        logic [7:0] rd;
        logic oer;
        bit oeb, ad;
        mem_lat = 1;
        mem_rdata = 8'h3C;
        p0 = perr_cnt;
        r0 = rd_cyc;
        do_phase(BUS_READ, 8'h00, 0, rl, fl, rd, oer, oeb, ad);
        nvec++; if (perr_cnt - p0 !== 1) begin nerr++; $display("FAIL err_reset_perr: got %0d pulses exp 1", perr_cnt - p0); end
        nvec++; if (last_addr !== 16'h0000) begin nerr++; $display("FAIL err_reset_addr: got %h exp 0000", last_addr); end
        nvec++; if (rd_cyc - r0 !== 1) begin nerr++; $display("FAIL err_reset_rdcyc: got %0d exp 1", rd_cyc - r0); end
        nvec++; if (rl !== SYNC + 3) begin nerr++; $display("FAIL err_reset_rise: got %0d exp %0d", rl, SYNC + 3); end
        nvec++; if (rd !== 8'h3C || oer !== 1'b1) begin nerr++; $display("FAIL err_reset_data: got %h/%b exp 3c/1", rd, oer); end
        nvec++; if (fl !== SYNC + 1 || oeb) begin nerr++; $display("FAIL err_reset_fall: got %0d oe_bad %0d exp %0d/0", fl, oeb, SYNC + 1); end
    endtask

    task automatic test_write();
        int rl, fl, w0, p0, u0;
        logic [7:0] rd;
        logic oer;
        bit oeb, ad;
        mem_lat = 1;
        w0 = wr_cyc;
        p0 = perr_cnt;
        u0 = unstable;
        do_phase(BUS_ADDR_LO, 8'h34, 0, rl, fl, rd, oer, oeb, ad);
        nvec++; if (rl !== SYNC + 1 || fl !== SYNC + 1) begin nerr++; $display("FAIL wr_lo_timing: got %0d/%0d exp %0d/%0d", rl, fl, SYNC + 1, SYNC + 1); end
        do_phase(BUS_ADDR_HI, 8'h12, 0, rl, fl, rd, oer, oeb, ad);
        nvec++; if (rl !== SYNC + 1 || oer !== 1'b0) begin nerr++; $display("FAIL wr_hi_ack: got %0d oe %b exp %0d oe 0", rl, oer, SYNC + 1); end
        do_phase(BUS_WRITE, 8'hA5, 0, rl, fl, rd, oer, oeb, ad);
        nvec++; if (rl !== SYNC + 3) begin nerr++; $display("FAIL wr_data_rise: got %0d exp %0d", rl, SYNC + 3); end
        nvec++; if (wr_cyc - w0 !== 1) begin nerr++; $display("FAIL wr_cycles: got %0d exp 1", wr_cyc - w0); end
        nvec++; if (last_addr !== 16'h1234) begin nerr++; $display("FAIL wr_addr: got %h exp 1234", last_addr); end
        nvec++; if (last_wdata !== 8'hA5) begin nerr++; $display("FAIL wr_wdata: got %h exp a5", last_wdata); end
        nvec++; if (perr_cnt - p0 !== 0) begin nerr++; $display("FAIL wr_perr: got %0d exp 0", perr_cnt - p0); end
        nvec++; if (oer !== 1'b0 || oeb || unstable - u0 !== 0) begin nerr++; $display("FAIL wr_oe_stable: got oe %b bad %0d unstable %0d exp 0/0/0", oer, oeb, unstable - u0); end
    endtask

    task automatic test_read_latency();
        int rl, fl, r0, p0;
        logic [7:0] rd;
        logic oer;
        bit oeb, ad;
        mem_lat = 3;
        mem_rdata = 8'h5C;
        r0 = rd_cyc;
        p0 = perr_cnt;
        do_phase(BUS_ADDR_LO, 8'h00, 0, rl, fl, rd, oer, oeb, ad);
        do_phase(BUS_ADDR_HI, 8'h80, 0, rl, fl, rd, oer, oeb, ad);
        do_phase(BUS_READ, 8'h00, 0, rl, fl, rd, oer, oeb, ad);
        nvec++; if (rd_cyc - r0 !== 3) begin nerr++; $display("FAIL rd_cycles: got %0d exp 3", rd_cyc - r0); end
        nvec++; if (last_addr !== 16'h8000) begin nerr++; $display("FAIL rd_addr: got %h exp 8000", last_addr); end
        nvec++; if (rl !== SYNC + 5) begin nerr++; $display("FAIL rd_rise: got %0d exp %0d", rl, SYNC + 5); end
        nvec++; if (rd !== 8'h5C || oer !== 1'b1) begin nerr++; $display("FAIL rd_data: got %h oe %b exp 5c oe 1", rd, oer); end
        nvec++; if (fl !== SYNC + 1 || oeb) begin nerr++; $display("FAIL rd_fall: got %0d oe_bad %0d exp %0d/0", fl, oeb, SYNC + 1); end
        nvec++; if (perr_cnt - p0 !== 0) begin nerr++; $display("FAIL rd_perr: got %0d exp 0", perr_cnt - p0); end
        mem_lat = 1;
    endtask

    task automatic test_stale_address();
        int rl, fl, p0;
        logic [7:0] rd;
        logic oer;
        bit oeb, ad;
        mem_rdata = 8'h9D;
        p0 = perr_cnt;
        do_phase(BUS_READ, 8'h00, 0, rl, fl, rd, oer, oeb, ad);
        nvec++; if (perr_cnt - p0 !== 1) begin nerr++; $display("FAIL stale_perr: got %0d exp 1", perr_cnt - p0); end
        nvec++; if (last_addr !== 16'h8000 || mem_addr !== 16'h8000) begin nerr++; $display("FAIL stale_addr: got %h/%h exp 8000", last_addr, mem_addr); end
        nvec++; if (rd !== 8'h9D || rl !== SYNC + 3) begin nerr++; $display("FAIL stale_data: got %h lat %0d exp 9d lat %0d", rd, rl, SYNC + 3); end
    endtask

    task automatic test_reset_mid_access();
        int rl, fl, p0;
        logic [7:0] rd;
        logic oer;
        bit oeb, ad, seen;
        do_phase(BUS_ADDR_LO, 8'h11, 0, rl, fl, rd, oer, oeb, ad);
        do_phase(BUS_ADDR_HI, 8'h22, 0, rl, fl, rd, oer, oeb, ad);
        mem_lat = 1000;
        @(negedge clk);
        bif.bus_state = BUS_READ;
        bif.bus_handshake_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_read === 1'b1) begin seen = 1'b1; break; end
        end
        nvec++; if (!seen) begin nerr++; $display("FAIL rstmid_strobe: got no mem_read exp mem_read within 20 cycles"); end
        rst = 1'b1;
        bif.bus_handshake_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        nvec++; if ({bif.bus_handshake_ack, mem_read, bif.bus_output_enable} !== 3'b000) begin nerr++; $display("FAIL rstmid_outputs: got %b exp 000", {bif.bus_handshake_ack, mem_read, bif.bus_output_enable}); end
        nvec++; if (dut.r_state !== IDLE || mem_addr !== 16'h0000) begin nerr++; $display("FAIL rstmid_state: got %0d addr %h exp %0d addr 0000", dut.r_state, mem_addr, IDLE); end
        mem_lat = 1;
        repeat (SYNC + 3) @(negedge clk);
        p0 = perr_cnt;
        do_phase(BUS_ADDR_LO, 8'hEF, 0, rl, fl, rd, oer, oeb, ad);
        do_phase(BUS_ADDR_HI, 8'hBE, 0, rl, fl, rd, oer, oeb, ad);
        do_phase(BUS_WRITE, 8'h77, 0, rl, fl, rd, oer, oeb, ad);
        nvec++; if (last_addr !== 16'hBEEF || last_wdata !== 8'h77) begin nerr++; $display("FAIL rstmid_beef: got %h/%h exp beef/77", last_addr, last_wdata); end
        nvec++; if (perr_cnt - p0 !== 0 || rl !== SYNC + 3 || fl !== SYNC + 1) begin nerr++; $display("FAIL rstmid_beef_hs: got perr %0d rise %0d fall %0d exp 0/%0d/%0d", perr_cnt - p0, rl, fl, SYNC + 3, SYNC + 1); end
    endtask

    task automatic test_hold_req();
        int rl, fl, a0;
        logic [7:0] rd;
        logic oer;
        bit oeb, ad;
        do_phase(BUS_ADDR_LO, 8'h01, 0, rl, fl, rd, oer, oeb, ad);
        do_phase(BUS_ADDR_HI, 8'h02, 0, rl, fl, rd, oer, oeb, ad);
        a0 = acc_cnt;
        do_phase(BUS_WRITE, 8'h5A, 10, rl, fl, rd, oer, oeb, ad);
        nvec++; if (ad) begin nerr++; $display("FAIL hold_ack: got ack dropped exp ack held high"); end
        nvec++; if (acc_cnt - a0 !== 1) begin nerr++; $display("FAIL hold_accesses: got %0d exp 1", acc_cnt - a0); end
        nvec++; if (fl !== SYNC + 1) begin nerr++; $display("FAIL hold_fall: got %0d exp %0d", fl, SYNC + 1); end
    endtask

    task automatic test_ready_ignored();
        int rl, fl, a0;
        logic [7:0] rd;
        logic oer;
        bit oeb, ad;
        a0 = acc_cnt;
        force_ready = 1'b1;
        repeat (5) @(negedge clk);
        do_phase(BUS_ADDR_LO, 8'h40, 0, rl, fl, rd, oer, oeb, ad);
        force_ready = 1'b0;
        nvec++; if (acc_cnt - a0 !== 0 || rl !== SYNC + 1) begin nerr++; $display("FAIL ready_idle: got acc %0d rise %0d exp 0/%0d", acc_cnt - a0, rl, SYNC + 1); end
    endtask

    task automatic test_glitch();
        int a0;
        bit bad;
        a0 = acc_cnt;
        bad = 1'b0;
        @(negedge clk);
        bif.bus_state = BUS_WRITE;
        bif.bus_handshake_req = 1'b1;
        #2;
        bif.bus_handshake_req = 1'b0;
        repeat (SYNC + 5) begin
            @(negedge clk);
            if (bif.bus_handshake_ack !== 1'b0 || dut.r_state !== IDLE) bad = 1'b1;
        end
        nvec++; if (bad || acc_cnt - a0 !== 0) begin nerr++; $display("FAIL glitch: got bad %0d acc %0d exp 0/0", bad, acc_cnt - a0); end
    endtask

    initial begin
        bif.bus_handshake_req = 1'b0;
        bif.bus_state = 2'b00;
        bif.bus_data_in = 8'h00;
        test_reset();
        test_error_after_reset();
        test_write();
        test_read_latency();
        test_stale_address();
        test_reset_mid_access();
        test_hold_req();
        test_ready_ignored();
        test_glitch();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
